// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache.
// Sits between the MEM-stage data port and word-addressed backing memory.
// Read hits return data combinationally. Read misses refill a 4-word line
// through a request/ack handshake. All writes go straight to memory.
// Optional read hit/miss counters are built when DCACHE_STATS_EN is defined;
// without it hit_count and miss_count are tied to zero.
module dcache #(
  parameter int LINES      = 16,
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_enable,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 28 - INDEX_BITS;
  localparam int WORDS = LINES * 4;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} state_t;

  state_t state_reg;
  state_t state_next;

  // Per-line storage; data is flattened as {index, word offset}.
  logic [LINES-1:0] valid_reg;
  logic [TAG_W-1:0] tag_mem  [0:LINES-1];
  logic [31:0]      data_mem [0:WORDS-1];

  // Latched access: line base for refills, full word address for writes.
  logic [31:2] addr_reg;
  logic [31:0] data_reg;
  logic [1:0]  k_reg;

  // Address decode of the live CPU access.
  logic [INDEX_BITS-1:0] cpu_index;
  logic [TAG_W-1:0]      cpu_tag;
  logic [1:0]            cpu_off;
  logic                  cpu_hit;
  logic                  is_read;
  logic                  is_write;

  // Address decode of the latched access.
  logic [INDEX_BITS-1:0] lat_index;
  logic [TAG_W-1:0]      lat_tag;
  logic                  lat_hit;

  // Byte-lane bits never matter to a word cache.
  logic unused_byte_bits;
  assign unused_byte_bits = &{1'b0, cpu_addr[1:0]};

  assign cpu_index = cpu_addr[4 +: INDEX_BITS];
  assign cpu_tag   = cpu_addr[31 -: TAG_W];
  assign cpu_off   = cpu_addr[3:2];
  assign cpu_hit   = valid_reg[cpu_index] && (tag_mem[cpu_index] == cpu_tag);

  // A store wins over a load when both are requested.
  assign is_write = cpu_enable & cpu_write;
  assign is_read  = cpu_enable & cpu_read & ~cpu_write;

  assign lat_index = addr_reg[4 +: INDEX_BITS];
  assign lat_tag   = addr_reg[31 -: TAG_W];
  assign lat_hit   = valid_reg[lat_index] && (tag_mem[lat_index] == lat_tag);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (is_write) begin
          state_next = WRITE;
        end else if (is_read && !cpu_hit) begin
          state_next = REFILL;
        end
      end
      REFILL: begin
        if (mem_ack && (k_reg == 2'd3)) begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs depend only on state, latched registers and CPU inputs, never on mem_ack.
  always_comb begin
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    cpu_rdata = 32'd0;
    case (state_reg)
      IDLE: begin
        if (is_write || (is_read && !cpu_hit)) begin
          stall = 1'b1;
        end
        if (is_read && cpu_hit) begin
          cpu_rdata = data_mem[{cpu_index, cpu_off}];
        end
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr_reg[31:4], k_reg, 2'b00};
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_reg, 2'b00};
        mem_wdata = data_reg;
      end
      DONE: begin
        stall = 1'b0;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  // Control registers: latch the access, track the refill word, manage valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
      k_reg     <= 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_write) begin
            addr_reg <= cpu_addr[31:2];
            data_reg <= cpu_wdata;
          end else if (is_read && !cpu_hit) begin
            // The resident line is about to be overwritten word by word.
            addr_reg             <= {cpu_addr[31:4], 2'b00};
            k_reg                <= 2'd0;
            valid_reg[cpu_index] <= 1'b0;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            k_reg <= k_reg + 2'd1;
            if (k_reg == 2'd3) begin
              valid_reg[lat_index] <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Tag and data arrays: refill words, final tag write, and write-through update on hit.
  always_ff @(posedge clk) begin
    if ((state_reg == REFILL) && mem_ack) begin
      data_mem[{lat_index, k_reg}] <= mem_rdata;
      if (k_reg == 2'd3) begin
        tag_mem[lat_index] <= lat_tag;
      end
    end else if ((state_reg == WRITE) && mem_ack && lat_hit) begin
      data_mem[{lat_index, addr_reg[3:2]}] <= data_reg;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_reg;
  logic [31:0] miss_reg;
  logic        hit_event;
  logic        miss_event;

  assign hit_event  = (state_reg == IDLE) && is_read && cpu_hit;
  assign miss_event = (state_reg == IDLE) && is_read && !cpu_hit;

  // Read hit/miss statistics, free-running and wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_reg  <= 32'd0;
      miss_reg <= 32'd0;
    end else begin
      if (hit_event) begin
        hit_reg <= hit_reg + 32'd1;
      end
      if (miss_event) begin
        miss_reg <= miss_reg + 32'd1;
      end
    end
  end

  assign hit_count  = hit_reg;
  assign miss_count = miss_reg;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed self-checking bench for dcache with a simple
// request/ack memory model whose ack delay is set per step.
module tb_dcache;

  logic        clk;
  logic        reset;
  logic        cpu_enable;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int tests = 0;
  int fails = 0;

  dcache #(.LINES(16), .INDEX_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_enable (cpu_enable),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: 256 words; untouched words hold a fixed pattern.
  int          a_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] wmem [0:255];
  bit          written [0:255];
  logic [31:0] log_addr [0:63];
  logic        log_we [0:63];
  int          log_n = 0;
  logic [7:0]  midx;

  function automatic logic [31:0] dflt(input logic [7:0] w);
    if (w >= 8'd16 && w <= 8'd19) return 32'h11 * ({24'd0, w} - 32'd15);
    return 32'hC000_0000 | {24'd0, w};
  endfunction

  assign midx      = mem_addr[9:2];
  assign mem_ack   = mem_req && (wait_cnt == a_delay);
  assign mem_rdata = written[midx] ? wmem[midx] : dflt(midx);

  always @(posedge clk) begin
    if (!mem_req) begin
      wait_cnt <= 0;
    end else if (mem_ack) begin
      wait_cnt <= 0;
      log_addr[log_n % 64] <= mem_addr;
      log_we[log_n % 64]   <= mem_we;
      log_n <= log_n + 1;
      if (mem_we) begin
        wmem[midx]    <= mem_wdata;
        written[midx] <= 1'b1;
      end
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input int exp_stalls);
    int n;
    @(negedge clk);
    cpu_enable = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = addr;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall"}, n, exp_stalls);
    check({tag, "_data"}, cpu_rdata, exp_data);
    @(posedge clk);
    #1;
    cpu_enable = 1'b0; cpu_read = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input int exp_stalls, input int exp_req);
    int n;
    int r;
    @(negedge clk);
    cpu_enable = 1'b1; cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = addr; cpu_wdata = data;
    #1;
    n = 0;
    r = 0;
    while (stall === 1'b1 && n < 200) begin
      if (mem_req && mem_we && mem_addr == addr && mem_wdata == data) r++;
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall"}, n, exp_stalls);
    check({tag, "_req_cycles"}, r, exp_req);
    cpu_enable = 1'b0; cpu_write = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    reset = 1'b1;
    cpu_enable = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_addr = 32'd0; cpu_wdata = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_hits", hit_count, 32'd0);
    check("rst_misses", miss_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Cold read miss with same-cycle ack, then a hit on the last word
    a_delay = 0;
    base = log_n;
    do_read("cold40", 32'h40, 32'h11, 5);
    check("cold40_nreq", log_n - base, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cold40_addr%0d", i), log_addr[(base + i) % 64], 32'h40 + 4 * i);
      check($sformatf("cold40_we%0d", i), {31'd0, log_we[(base + i) % 64]}, 32'd0);
    end
    do_read("hit4c", 32'h4C, 32'h44, 0);
`ifdef DCACHE_STATS_EN
    check("stats_miss", miss_count, 32'd1);
    check("stats_hit", hit_count, 32'd2);
`else
    check("stats_miss", miss_count, 32'd0);
    check("stats_hit", hit_count, 32'd0);
`endif

    // Write hit with ack delay 2, then read back from cache
    a_delay = 2;
    base = log_n;
    do_write("wr44", 32'h44, 32'hDEADBEEF, 4, 3);
    check("wr44_nreq", log_n - base, 1);
    check("wr44_we", {31'd0, log_we[base % 64]}, 32'd1);
    do_read("rd44", 32'h44, 32'hDEADBEEF, 0);

    // Write miss does not allocate: one memory write, then a refill
    a_delay = 0;
    base = log_n;
    do_write("wr80", 32'h80, 32'h12345678, 2, 1);
    check("wr80_nreq", log_n - base, 1);
    base = log_n;
    do_read("rd80", 32'h80, 32'h12345678, 5);
    check("rd80_nreq", log_n - base, 4);
    check("rd80_addr0", log_addr[base % 64], 32'h80);

    // Conflict misses on one index
    base = log_n;
    do_read("conf000a", 32'h000, 32'hC000_0000, 5);
    do_read("conf100", 32'h100, 32'hC000_0040, 5);
    do_read("conf000b", 32'h000, 32'hC000_0000, 5);
    check("conf_nreq", log_n - base, 12);

    // Reset in the middle of a refill at k=2
    a_delay = 1;
    base = log_n;
    @(negedge clk);
    cpu_enable = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h200;
    n = 0;
    while ((log_n - base) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("mid_req", {31'd0, mem_req}, 32'd1);
    check("mid_addr", mem_addr, 32'h208);
    reset = 1'b1;
    cpu_enable = 1'b0; cpu_read = 1'b0;
    #1;
    check("rstmid_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    base = log_n;
    do_read("reread200", 32'h200, 32'hC000_0080, 9);
    check("reread_nreq", log_n - base, 4);
    check("reread_addr0", log_addr[base % 64], 32'h200);
`ifdef DCACHE_STATS_EN
    check("stats2_miss", miss_count, 32'd1);
    check("stats2_hit", hit_count, 32'd1);
`else
    check("stats2_miss", miss_count, 32'd0);
    check("stats2_hit", hit_count, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache between the CPU's MEM-stage data port and the word-addressed backing memory. Read hits return data combinationally in the access cycle. Misses and all writes raise `stall`, which freezes the pipeline, while a small FSM runs a request/ack handshake with memory. Read misses refill a full 4-word line.

## Interface
Parameters:
- `LINES`, 16: number of lines; power of two, 2..256.
- `INDEX_BITS`, 4: log2(`LINES`); must match `LINES`.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `cpu_enable` input 1: access valid this cycle (MEM stage, non-IO).
- `cpu_read` input 1: load request.
- `cpu_write` input 1: store request; wins if asserted together with `cpu_read`.
- `cpu_addr` input 32: byte address; bits [1:0] ignored.
- `cpu_wdata` input 32: store data.
- `cpu_rdata` output 32: load data; valid when `stall`=0 on a read.
- `stall` output 1: hold the pipeline.
- `mem_req` output 1: memory request.
- `mem_we` output 1: 1 = write, 0 = read.
- `mem_addr` output 32: word-aligned memory address.
- `mem_wdata` output 32: write data.
- `mem_rdata` input 32: read data, valid with `mem_ack`.
- `mem_ack` input 1: one-cycle completion pulse; may assert in the first `mem_req` cycle.
- `hit_count` output 32: read-hit counter (see Configuration).
- `miss_count` output 32: read-miss counter (see Configuration).

## Operation
- Address split:
  - offset = `cpu_addr[3:2]`
  - index = `cpu_addr[4+INDEX_BITS-1:4]`
  - tag = `cpu_addr[31:4+INDEX_BITS]`
- Storage per line: valid bit, tag, 4×32 data. Arrays are register-based with combinational read.
- Hit = `valid[index]` and the stored tag equals the address tag.
- FSM states: IDLE, REFILL, WRITE, DONE.
- IDLE:
  - Read hit: `cpu_rdata` = word[offset], `stall`=0, no memory traffic.
  - Read miss: `stall`=1. Latch line base = {tag, index, 4'b0000}, set word counter k=0, go to REFILL.
  - Write (hit or miss): `stall`=1. Latch address and data, go to WRITE.
  - `cpu_enable`=0 or neither read nor write: `stall`=0, stay in IDLE.
- REFILL:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr` = base + 4k.
  - On `mem_ack`: store `mem_rdata` into word k and increment k.
  - On the ack with k=3: write tag, set valid, go to IDLE. The held access then hits.
  - `stall`=1 throughout.
- WRITE:
  - Drive `mem_req`=1, `mem_we`=1, latched address and data.
  - On `mem_ack`: if the latched address hits, update that cached word. Go to DONE.
  - A write miss does not allocate.
  - `stall`=1 throughout.
- DONE:
  - `stall`=0 for exactly one cycle so the pipeline retires the store.
  - CPU inputs are ignored this cycle.
  - Go to IDLE.
- Refill replaces the resident line unconditionally. Write-through means there is no dirty data.

## Timing
Reset values:
- state = IDLE, all valid bits = 0, counters = 0, k = 0.
- `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- `cpu_rdata`=0 while not hitting.
- `stall`=0.

Latency (A = ack delay per word in cycles, 0 = ack in the same cycle as the request):
- Read hit: 0 cycles; `stall` is never raised.
- Read miss: `stall` is high for 1 + 4·(A+1) cycles, then the hit cycle follows. With A=0: 5 stall cycles.
- Write: `stall` is high for 1 + (A+1) cycles, then DONE with `stall`=0.

Rules:
- `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` stay stable from request until ack.
- `mem_req` drops, or moves to the next word, on the edge after the ack.
- `mem_ack` seen while `mem_req`=0 is ignored.
- Reset mid-REFILL: `mem_req` drops immediately (asynchronous), the line stays invalid, and data already written to that line is don't-care.
- Reset mid-WRITE: the memory write may or may not have completed.
- `stall` is a function of state and current inputs only; it never depends combinationally on `mem_ack`.

## Configuration
- Macro `DCACHE_STATS_EN`.
- Defined:
  - `hit_count` increments on each read hit completed in IDLE. This includes the post-refill hit.
  - `miss_count` increments on each IDLE→REFILL transition.
  - Both wrap at 2^32 and are cleared by reset.
- Undefined: no counter registers are built, and both outputs are tied to 0.

## Test plan
- Cold read of 0x00000040, A=0, memory returns 0x11,0x22,0x33,0x44 → `mem_addr` sequence 0x40,0x44,0x48,0x4C; 5 stall cycles; `cpu_rdata`=0x11. A following read of 0x4C hits with `cpu_rdata`=0x44 and `stall`=0.
- Write 0xDEADBEEF to 0x44 after that refill, A=2 → `mem_req`/`mem_we` high with the same address for 3 cycles, then DONE. A read of 0x44 hits with 0xDEADBEEF.
- Write to uncached 0x80, then read 0x80 → exactly one memory write, then a refill (miss), proving no allocation.
- `LINES`=16: read 0x000, then 0x100 (same index, different tag), then 0x000 → three misses, 12 memory reads.
- Assert `reset` during REFILL at k=2 → `mem_req`=0 immediately. A re-read of the same address misses and refills from word 0.
- With `DCACHE_STATS_EN`, run the first scenario → `miss_count`=1, `hit_count`=2. Without the macro → both read 0.
